// File: rtl/mm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mm_arbiter
//  Description : Shares the single mainmemory line port between two L1 cache
//                masters. Grants one line read (fill) or line write (evict)
//                at a time, issues a one-cycle command to mainmemory, tracks
//                read latency / write occupancy and returns a one-cycle done
//                (plus read data on a fill) to the granted master.
//                Optional build macro MM_ARB_FIXED_PRI_EN: when defined,
//                port 0 always wins simultaneous requests (no round-robin
//                pointer); when undefined, arbitration is round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module mm_arbiter #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 256,
    parameter int BE_WIDTH   = 32,
    parameter int WRITE_TPUT = 4      // legal 1..15
) (
    input  logic                  clk,
    input  logic                  reset,      // asynchronous, active low

    // Port 0 (cache master 0)
    input  logic [ADDR_WIDTH-1:0] p0_a,
    input  logic                  p0_read,
    input  logic                  p0_write,
    input  logic [DATA_WIDTH-1:0] p0_wd,
    input  logic [BE_WIDTH-1:0]   p0_be,
    output logic [DATA_WIDTH-1:0] p0_rd,
    output logic                  p0_done,

    // Port 1 (cache master 1)
    input  logic [ADDR_WIDTH-1:0] p1_a,
    input  logic                  p1_read,
    input  logic                  p1_write,
    input  logic [DATA_WIDTH-1:0] p1_wd,
    input  logic [BE_WIDTH-1:0]   p1_be,
    output logic [DATA_WIDTH-1:0] p1_rd,
    output logic                  p1_done,

    // Mainmemory side
    output logic [ADDR_WIDTH-1:0] mm_a,
    output logic                  mm_read,
    output logic                  mm_write,
    output logic [DATA_WIDTH-1:0] mm_wd,
    output logic [BE_WIDTH-1:0]   mm_be,
    input  logic [DATA_WIDTH-1:0] mm_rd,
    input  logic                  mm_valid,

    // Status
    output logic                  gnt_id,
    output logic                  busy,
    output logic                  err_spurious
);

    // Write occupancy counter load value; the done pulse lands in the last
    // of the WRITE_TPUT cycles, counting the mm_write cycle as the first.
    localparam logic [3:0] C_CNT_LOAD = 4'(WRITE_TPUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_BUSY = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and registered command outputs
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  r_gnt;
    logic                  w_gnt_nxt;
    logic [ADDR_WIDTH-1:0] r_mm_a;
    logic [ADDR_WIDTH-1:0] w_mm_a_nxt;
    logic [DATA_WIDTH-1:0] r_mm_wd;
    logic [DATA_WIDTH-1:0] w_mm_wd_nxt;
    logic [BE_WIDTH-1:0]   r_mm_be;
    logic [BE_WIDTH-1:0]   w_mm_be_nxt;
    logic                  r_mm_read;
    logic                  w_mm_read_nxt;
    logic                  r_mm_write;
    logic                  w_mm_write_nxt;
`ifndef MM_ARB_FIXED_PRI_EN
    logic                  r_last;
    logic                  w_last_nxt;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                  w_req0;
    logic                  w_req1;
    logic                  w_win;      // winning port index (valid when a request exists)
    logic                  w_win_rd;   // winner wants a read (read beats write on one port)
    logic [ADDR_WIDTH-1:0] w_win_a;
    logic [DATA_WIDTH-1:0] w_win_wd;
    logic [BE_WIDTH-1:0]   w_win_be;

    assign w_req0 = p0_read | p0_write;
    assign w_req1 = p1_read | p1_write;

`ifdef MM_ARB_FIXED_PRI_EN
    // Port 0 wins whenever it asks; port 1 only when port 0 is silent.
    assign w_win = ~w_req0;
`else
    // On contention the port that did not win last time gets the grant.
    assign w_win = (w_req0 & w_req1) ? ~r_last : w_req1;
`endif

    assign w_win_rd = w_win ? p1_read : p0_read;
    assign w_win_a  = w_win ? p1_a    : p0_a;
    assign w_win_wd = w_win ? p1_wd   : p0_wd;
    assign w_win_be = w_win ? p1_be   : p0_be;

    // State register plus registered mainmemory command and grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_gnt      <= 1'b0;
            r_mm_a     <= '0;
            r_mm_wd    <= '0;
            r_mm_be    <= '0;
            r_mm_read  <= 1'b0;
            r_mm_write <= 1'b0;
`ifndef MM_ARB_FIXED_PRI_EN
            r_last     <= 1'b1;    // port 0 gets first pick after reset
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gnt      <= w_gnt_nxt;
            r_mm_a     <= w_mm_a_nxt;
            r_mm_wd    <= w_mm_wd_nxt;
            r_mm_be    <= w_mm_be_nxt;
            r_mm_read  <= w_mm_read_nxt;
            r_mm_write <= w_mm_write_nxt;
`ifndef MM_ARB_FIXED_PRI_EN
            r_last     <= w_last_nxt;
`endif
        end
    end

    // Next-state, grant/command capture and same-cycle done/read-data routing.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_gnt_nxt      = r_gnt;
        w_mm_a_nxt     = r_mm_a;
        w_mm_wd_nxt    = r_mm_wd;
        w_mm_be_nxt    = r_mm_be;
        w_mm_read_nxt  = 1'b0;
        w_mm_write_nxt = 1'b0;
`ifndef MM_ARB_FIXED_PRI_EN
        w_last_nxt     = r_last;
`endif
        p0_done        = 1'b0;
        p1_done        = 1'b0;
        p0_rd          = '0;
        p1_rd          = '0;

        case (r_state)
            S_IDLE: begin
                if (w_req0 | w_req1) begin
                    w_gnt_nxt   = w_win;
`ifndef MM_ARB_FIXED_PRI_EN
                    w_last_nxt  = w_win;
`endif
                    w_mm_a_nxt  = w_win_a;
                    w_mm_wd_nxt = w_win_wd;
                    w_mm_be_nxt = w_win_be;
                    if (w_win_rd) begin
                        w_mm_read_nxt  = 1'b1;
                        w_state_nxt    = S_RD_WAIT;
                    end else begin
                        w_mm_write_nxt = 1'b1;
                        w_cnt_nxt      = C_CNT_LOAD;
                        w_state_nxt    = S_WR_BUSY;
                    end
                end
            end

            S_RD_WAIT: begin
                // Read data is forwarded combinationally in the valid cycle.
                if (mm_valid) begin
                    if (r_gnt) begin
                        p1_done = 1'b1;
                        p1_rd   = mm_rd;
                    end else begin
                        p0_done = 1'b1;
                        p0_rd   = mm_rd;
                    end
                    w_state_nxt = S_IDLE;
                end
            end

            S_WR_BUSY: begin
                if (r_cnt == 4'd0) begin
                    if (r_gnt) begin
                        p1_done = 1'b1;
                    end else begin
                        p0_done = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output drive. A response arriving while not waiting for one (including
    // one still in flight across a reset) is flagged but never routed; the
    // flag is held low while reset is asserted.
    assign mm_a         = r_mm_a;
    assign mm_wd        = r_mm_wd;
    assign mm_be        = r_mm_be;
    assign mm_read      = r_mm_read;
    assign mm_write     = r_mm_write;
    assign gnt_id       = r_gnt;
    assign busy         = (r_state != S_IDLE);
    assign err_spurious = reset & mm_valid & (r_state != S_RD_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_mm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mm_arbiter
//  Description : Directed self-checking bench for mm_arbiter with a
//                command/done scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_arbiter;

    logic         clk;
    logic         reset;
    logic [26:0]  p0_a, p1_a, mm_a;
    logic         p0_read, p0_write, p1_read, p1_write;
    logic [255:0] p0_wd, p1_wd, p0_rd, p1_rd, mm_wd, mm_rd;
    logic [31:0]  p0_be, p1_be, mm_be;
    logic         p0_done, p1_done, mm_read, mm_write, mm_valid;
    logic         gnt_id, busy, err_spurious;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         port;
        logic         rd;
        logic [26:0]  a;
        logic [255:0] wd;
        logic [31:0]  be;
    } cmd_t;

    typedef struct {
        logic         port;
        logic         chk_rd;
        logic [255:0] rd;
    } done_t;

    cmd_t  cmd_q[$];
    done_t done_q[$];

    mm_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .p0_a         (p0_a),
        .p0_read      (p0_read),
        .p0_write     (p0_write),
        .p0_wd        (p0_wd),
        .p0_be        (p0_be),
        .p0_rd        (p0_rd),
        .p0_done      (p0_done),
        .p1_a         (p1_a),
        .p1_read      (p1_read),
        .p1_write     (p1_write),
        .p1_wd        (p1_wd),
        .p1_be        (p1_be),
        .p1_rd        (p1_rd),
        .p1_done      (p1_done),
        .mm_a         (mm_a),
        .mm_read      (mm_read),
        .mm_write     (mm_write),
        .mm_wd        (mm_wd),
        .mm_be        (mm_be),
        .mm_rd        (mm_rd),
        .mm_valid     (mm_valid),
        .gnt_id       (gnt_id),
        .busy         (busy),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive point: just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample point: falling edge of the current cycle.
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push_cmd(input logic port, input logic rd, input logic [26:0] a,
                            input logic [255:0] wd, input logic [31:0] be);
        cmd_t c;
        c.port = port; c.rd = rd; c.a = a; c.wd = wd; c.be = be;
        cmd_q.push_back(c);
    endtask

    task automatic push_done(input logic port, input logic chk_rd, input logic [255:0] rd);
        done_t d;
        d.port = port; d.chk_rd = chk_rd; d.rd = rd;
        done_q.push_back(d);
    endtask

    // Scoreboard: every mainmemory command must match the next expected one.
    always @(negedge clk) begin : mon_cmd
        cmd_t c;
        if (reset && (mm_read || mm_write)) begin
            chk("cmd_expected", (cmd_q.size() != 0), 1);
            chk("cmd_onehot", (mm_read & mm_write), 0);
            if (cmd_q.size() != 0) begin
                c = cmd_q.pop_front();
                chk("cmd_port", gnt_id, c.port);
                chk("cmd_kind_read", mm_read, c.rd);
                chk("cmd_addr", mm_a, c.a);
                if (!c.rd) begin
                    chk("cmd_wd", mm_wd, c.wd);
                    chk("cmd_be", mm_be, c.be);
                end
            end
        end
    end

    // Scoreboard: every done pulse must match the next expected completion.
    always @(negedge clk) begin : mon_done
        done_t d;
        if (p0_done || p1_done) begin
            chk("done_expected", (done_q.size() != 0), 1);
            chk("done_onehot", (p0_done & p1_done), 0);
            if (done_q.size() != 0) begin
                d = done_q.pop_front();
                chk("done_port", p1_done, d.port);
                if (d.chk_rd) begin
                    chk("done_rd", (d.port ? p1_rd : p0_rd), d.rd);
                    chk("done_other_rd", (d.port ? p0_rd : p1_rd), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [255:0] rd_a5;
        logic [255:0] rd_pat;
        logic [255:0] wd_pat;
        rd_a5  = {8{32'hA5A5A5A5}};
        wd_pat = {8{32'hDEADBEEF}};

        reset = 1'b0;
        p0_a = '0; p0_read = 1'b0; p0_write = 1'b0; p0_wd = '0; p0_be = '0;
        p1_a = '0; p1_read = 1'b0; p1_write = 1'b0; p1_wd = '0; p1_be = '0;
        mm_rd = '1; mm_valid = 1'b1;    // stray response during reset

        // ---------------- reset state ----------------
        smp(); smp();
        chk("rst_mm_read", mm_read, 0);
        chk("rst_mm_write", mm_write, 0);
        chk("rst_mm_a", mm_a, 0);
        chk("rst_mm_wd", mm_wd, 0);
        chk("rst_mm_be", mm_be, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt_id, 0);
        chk("rst_p0_done", p0_done, 0);
        chk("rst_p1_done", p1_done, 0);
        chk("rst_p0_rd", p0_rd, 0);
        chk("rst_p1_rd", p1_rd, 0);
        chk("rst_err", err_spurious, 0);
        step(); mm_valid = 1'b0; reset = 1'b1;
        step();

        // ---------------- single read, port 0 ----------------
        step(); p0_read = 1'b1; p0_a = 27'h0000123;
        push_cmd(1'b0, 1'b1, 27'h0000123, '0, '0);
        smp(); chk("rd_no_early_cmd", mm_read, 0);
        step(); smp();
        chk("rd_cmd", mm_read, 1);
        chk("rd_addr", mm_a, 27'h0000123);
        chk("rd_busy", busy, 1);
        chk("rd_gnt", gnt_id, 0);
        step(); smp();
        chk("rd_cmd_one_pulse", mm_read, 0);
        chk("rd_no_early_done", p0_done, 0);
        step(); step();
        step(); mm_valid = 1'b1; mm_rd = rd_a5; push_done(1'b0, 1'b1, rd_a5);
        smp();
        chk("rd_p0_done", p0_done, 1);
        chk("rd_p0_rd", p0_rd, rd_a5);
        chk("rd_p1_done", p1_done, 0);
        chk("rd_err", err_spurious, 0);
        step(); mm_valid = 1'b0; p0_read = 1'b0;
        smp();
        chk("rd_idle_busy", busy, 0);
        chk("rd_done_pulse", p0_done, 0);

        // ---------------- single write, port 1 ----------------
        step(); p1_write = 1'b1; p1_a = 27'h0000456; p1_wd = 256'h1; p1_be = 32'hFFFFFFFF;
        push_cmd(1'b1, 1'b0, 27'h0000456, 256'h1, 32'hFFFFFFFF);
        step(); smp();
        chk("wr_cmd", mm_write, 1);
        chk("wr_busy", busy, 1);
        chk("wr_gnt", gnt_id, 1);
        for (int k = 0; k < 2; k++) begin
            step(); smp();
            chk("wr_cmd_one_pulse", mm_write, 0);
            chk("wr_no_early_done", p1_done, 0);
        end
        step(); push_done(1'b1, 1'b0, '0);
        smp(); chk("wr_p1_done", p1_done, 1);
        chk("wr_p0_done", p0_done, 0);
        step(); p1_write = 1'b0;
        smp();
        chk("wr_idle_busy", busy, 0);
        chk("wr_mm_a_held", mm_a, 27'h0000456);

        // ---------------- contention, round-robin 0,1,0 ----------------
        step(); p0_read = 1'b1; p1_read = 1'b1; p0_a = 27'h10; p1_a = 27'h20;
        push_cmd(1'b0, 1'b1, 27'h10, '0, '0);
        push_cmd(1'b1, 1'b1, 27'h20, '0, '0);
        push_cmd(1'b0, 1'b1, 27'h10, '0, '0);
        for (int i = 0; i < 3; i++) begin
            step(); smp();
            chk("rr_cmd", mm_read, 1);
            chk("rr_gnt", gnt_id, (i == 1));
            step(); step();
            rd_pat = {8{32'h01000000 * (i + 1)}};
            mm_valid = 1'b1; mm_rd = rd_pat;
            push_done((i == 1), 1'b1, rd_pat);
            smp();
            chk("rr_done_p0", p0_done, (i != 1));
            chk("rr_done_p1", p1_done, (i == 1));
            step(); mm_valid = 1'b0;
            if (i == 2) begin
                p0_read = 1'b0; p1_read = 1'b0;
            end
            smp();
            chk("rr_gap_busy", busy, 0);
            chk("rr_gap_cmd", mm_read, 0);
        end

        // ---------------- spurious response in IDLE ----------------
        step(); mm_valid = 1'b1; mm_rd = '1;
        smp();
        chk("sp_idle_err", err_spurious, 1);
        chk("sp_idle_p0_done", p0_done, 0);
        chk("sp_idle_p1_done", p1_done, 0);
        chk("sp_idle_p0_rd", p0_rd, 0);
        step(); mm_valid = 1'b0;
        smp(); chk("sp_idle_err_pulse", err_spurious, 0);

        // ---------------- spurious response during WR_BUSY ----------------
        step(); p0_write = 1'b1; p0_a = 27'h77; p0_wd = wd_pat; p0_be = 32'h0F0F0F0F;
        push_cmd(1'b0, 1'b0, 27'h77, wd_pat, 32'h0F0F0F0F);
        step(); smp(); chk("spw_cmd", mm_write, 1);
        step(); mm_valid = 1'b1;
        smp();
        chk("spw_err", err_spurious, 1);
        chk("spw_no_done", p0_done, 0);
        step(); mm_valid = 1'b0;
        smp();
        chk("spw_err_pulse", err_spurious, 0);
        chk("spw_no_done2", p0_done, 0);
        step(); push_done(1'b0, 1'b0, '0);
        smp(); chk("spw_done", p0_done, 1);
        step(); p0_write = 1'b0;
        smp(); chk("spw_idle", busy, 0);

        // ---------------- reset in the middle of a read ----------------
        step(); p0_read = 1'b1; p0_a = 27'h99;
        push_cmd(1'b0, 1'b1, 27'h99, '0, '0);
        step(); smp(); chk("rst_mid_cmd", mm_read, 1);
        step(); smp(); chk("rst_mid_busy", busy, 1);
        #1 reset = 1'b0;
        #1;
        chk("rst_async_busy", busy, 0);
        chk("rst_async_mm_a", mm_a, 0);
        chk("rst_async_wd", mm_wd, 0);
        chk("rst_async_gnt", gnt_id, 0);
        p0_read = 1'b0;
        step(); reset = 1'b1; mm_valid = 1'b1; mm_rd = rd_a5;
        smp();
        chk("rst_late_err", err_spurious, 1);
        chk("rst_late_p0_done", p0_done, 0);
        chk("rst_late_p0_rd", p0_rd, 0);
        step(); mm_valid = 1'b0; p1_read = 1'b1; p1_a = 27'h55;
        push_cmd(1'b1, 1'b1, 27'h55, '0, '0);
        step(); smp();
        chk("rst_new_cmd", mm_read, 1);
        chk("rst_new_gnt", gnt_id, 1);
        step(); mm_valid = 1'b1; mm_rd = ~rd_a5; push_done(1'b1, 1'b1, ~rd_a5);
        smp(); chk("rst_new_done", p1_done, 1);
        step(); mm_valid = 1'b0; p1_read = 1'b0;
        smp(); chk("rst_new_idle", busy, 0);

        // ---------------- same-port read + write ----------------
        step(); p0_read = 1'b1; p0_write = 1'b1; p0_a = 27'h3A; p0_wd = wd_pat; p0_be = 32'hFFFF0000;
        push_cmd(1'b0, 1'b1, 27'h3A, '0, '0);
        step(); smp();
        chk("rw_first_read", mm_read, 1);
        chk("rw_first_nowrite", mm_write, 0);
        step(); mm_valid = 1'b1; mm_rd = rd_a5; push_done(1'b0, 1'b1, rd_a5);
        smp(); chk("rw_done1", p0_done, 1);
        step(); mm_valid = 1'b0;
        push_cmd(1'b0, 1'b1, 27'h3A, '0, '0);
        smp(); chk("rw_gap", busy, 0);
        step(); smp();
        chk("rw_reread", mm_read, 1);
        chk("rw_reread_nowrite", mm_write, 0);
        step(); mm_valid = 1'b1; push_done(1'b0, 1'b1, rd_a5);
        smp(); chk("rw_done2", p0_done, 1);
        step(); mm_valid = 1'b0; p0_read = 1'b0;
        push_cmd(1'b0, 1'b0, 27'h3A, wd_pat, 32'hFFFF0000);
        smp(); chk("rw_gap2", busy, 0);
        step(); smp(); chk("rw_write", mm_write, 1);
        for (int k = 0; k < 2; k++) begin
            step(); smp(); chk("rw_wr_no_early_done", p0_done, 0);
        end
        step(); push_done(1'b0, 1'b0, '0);
        smp(); chk("rw_wr_done", p0_done, 1);
        step(); p0_write = 1'b0;
        smp(); chk("rw_end_idle", busy, 0);

        step(); step();
        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
